// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: trace-capture unit beside the CPU core.
// Each valid cycle, {instr, ALUResult, cpu_out} is written into a circular
// buffer. A pre-trigger window is kept and a post-trigger window is recorded
// around an instruction-match trigger, and then the buffer freezes. The
// frozen record is read out oldest-first.
//
// Optional feature: define TRACE_TIMESTAMP_EN to add a free-running TS_W-bit
// cycle counter whose value is stored in the MSBs of every entry.
//
// Ports:
//   CLK, reset          clock; synchronous active-high reset
//   sample_valid        instr/ALUResult/cpu_out form one sample this cycle
//   instr, ALUResult,   traced sample fields
//   cpu_out
//   arm                 pulse that starts a capture (from IDLE or DONE)
//   stop                forces the freeze (from ARMED or POST)
//   trig_value/_mask    trigger compare; a mask bit of 1 compares that bit
//   rd_req              pop one entry while DONE
//   rd_data/_valid/_last  registered read port, one cycle after rd_req
//   state               IDLE=0, ARMED=1, POST=2, DONE=3
//   count               entries held
//   triggered           the record contains a trigger sample
module cpu_trace_buffer #(
   parameter int unsigned INSTR_W  = 24,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned PRE_TRIG = 4,
   parameter int unsigned TS_W     = 16,
`ifdef TRACE_TIMESTAMP_EN
   localparam int unsigned TS_BITS = TS_W,
`else
   localparam int unsigned TS_BITS = 0 * TS_W,
`endif
   localparam int unsigned ENTRY_W = TS_BITS + INSTR_W + 2 * DATA_W,
   localparam int unsigned PW      = $clog2(DEPTH),
   localparam int unsigned CW      = PW + 1
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               sample_valid,
   input  logic [INSTR_W-1:0] instr,
   input  logic [DATA_W-1:0]  ALUResult,
   input  logic [DATA_W-1:0]  cpu_out,
   input  logic               arm,
   input  logic               stop,
   input  logic [INSTR_W-1:0] trig_value,
   input  logic [INSTR_W-1:0] trig_mask,
   input  logic               rd_req,
   output logic [ENTRY_W-1:0] rd_data,
   output logic               rd_valid,
   output logic               rd_last,
   output logic [1:0]         state,
   output logic [CW-1:0]      count,
   output logic               triggered
);

   localparam int unsigned POST_LEN = DEPTH - PRE_TRIG - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e             state_q;
   logic [CW-1:0]      count_q;
   logic [PW-1:0]      wr_ptr_q;
   logic [PW-1:0]      post_left_q;
   logic               trig_q;
   logic               rd_valid_q;
   logic               rd_last_q;
   logic [ENTRY_W-1:0] rd_data_q;
   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic               hit;
   logic               wr_en;
   logic [PW-1:0]      rd_ptr;
   logic [ENTRY_W-1:0] wr_entry;

   assign hit    = sample_valid && (((instr ^ trig_value) & trig_mask) == '0);
   assign wr_en  = !reset && sample_valid && (state_q == S_ARMED || state_q == S_POST);
   // Oldest held entry; count shrinks on each pop so this walks forward.
   assign rd_ptr = wr_ptr_q - count_q[PW-1:0];

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;

   // Free-running cycle counter stamped into each entry.
   always_ff @(posedge CLK) begin
      if (reset) ts_q <= '0;
      else       ts_q <= ts_q + 1'b1;
   end

   assign wr_entry = {ts_q, instr, ALUResult, cpu_out};
`else
   assign wr_entry = {instr, ALUResult, cpu_out};
`endif

   // Trace storage; contents are intentionally not reset.
   always_ff @(posedge CLK) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
   end

   // Capture / readout control.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         post_left_q <= '0;
         trig_q      <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  count_q  <= '0;
                  wr_ptr_q <= '0;
                  trig_q   <= 1'b0;
                  state_q  <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (sample_valid) begin
                  wr_ptr_q <= wr_ptr_q + 1'b1;
                  // Pre-trigger window saturates; the hit sample always adds one.
                  if (hit || count_q < CW'(PRE_TRIG)) count_q <= count_q + 1'b1;
               end
               if (hit) begin
                  trig_q      <= 1'b1;
                  post_left_q <= PW'(POST_LEN);
                  state_q     <= (POST_LEN == 0 || stop) ? S_DONE : S_POST;
               end else if (stop) begin
                  state_q <= S_DONE;
               end
            end
            S_POST: begin
               if (sample_valid) begin
                  wr_ptr_q    <= wr_ptr_q + 1'b1;
                  count_q     <= count_q + 1'b1;
                  post_left_q <= post_left_q - 1'b1;
               end
               if (stop || (sample_valid && post_left_q == PW'(1))) state_q <= S_DONE;
            end
            S_DONE: begin
               if (arm) begin
                  count_q  <= '0;
                  wr_ptr_q <= '0;
                  trig_q   <= 1'b0;
                  state_q  <= S_ARMED;
               end else if (rd_req && count_q != '0) begin
                  rd_data_q  <= mem_q[rd_ptr];
                  rd_valid_q <= 1'b1;
                  rd_last_q  <= (count_q == CW'(1));
                  count_q    <= count_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign state     = state_q;
   assign count     = count_q;
   assign triggered = trig_q;
   assign rd_valid  = rd_valid_q;
   assign rd_last   = rd_last_q;
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the capture window.
module tb_cpu_trace_buffer;

   localparam int unsigned INSTR_W  = 24;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned PRE_TRIG = 4;
   localparam int unsigned TS_W     = 16;
`ifdef TRACE_TIMESTAMP_EN
   localparam int unsigned ENTRY_W  = TS_W + INSTR_W + 2 * DATA_W;
`else
   localparam int unsigned ENTRY_W  = INSTR_W + 2 * DATA_W;
`endif
   localparam int unsigned CW       = $clog2(DEPTH) + 1;

   logic               CLK = 1'b0;
   logic               reset;
   logic               sample_valid;
   logic [INSTR_W-1:0] instr;
   logic [DATA_W-1:0]  ALUResult;
   logic [DATA_W-1:0]  cpu_out;
   logic               arm;
   logic               stop;
   logic [INSTR_W-1:0] trig_value;
   logic [INSTR_W-1:0] trig_mask;
   logic               rd_req;
   logic [ENTRY_W-1:0] rd_data;
   logic               rd_valid;
   logic               rd_last;
   logic [1:0]         state;
   logic [CW-1:0]      count;
   logic               triggered;

   cpu_trace_buffer dut (
      .CLK(CLK), .reset(reset), .sample_valid(sample_valid), .instr(instr),
      .ALUResult(ALUResult), .cpu_out(cpu_out), .arm(arm), .stop(stop),
      .trig_value(trig_value), .trig_mask(trig_mask), .rd_req(rd_req),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
      .state(state), .count(count), .triggered(triggered)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Model: the record is simply a queue of captured entries, oldest first.
   logic [ENTRY_W-1:0] m_q[$];
   int                 m_state = 0;
   int                 m_post  = 0;
   bit                 m_trig  = 1'b0;
   bit                 m_rd_valid = 1'b0;
   bit                 m_rd_last  = 1'b0;
   logic [ENTRY_W-1:0] m_rd_data  = '0;
   logic [TS_W-1:0]    m_ts = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [ENTRY_W-1:0] mk_entry();
`ifdef TRACE_TIMESTAMP_EN
      return {m_ts, instr, ALUResult, cpu_out};
`else
      return {instr, ALUResult, cpu_out};
`endif
   endfunction

   // Advance the model by one clock edge using the inputs the DUT just sampled.
   task automatic m_step();
      bit hit;
      logic [ENTRY_W-1:0] e;
      hit = sample_valid && (((instr ^ trig_value) & trig_mask) == '0);
      e = mk_entry();
      m_rd_valid = 1'b0;
      m_rd_last  = 1'b0;
      if (reset) begin
         m_q.delete();
         m_state = 0; m_post = 0; m_trig = 1'b0; m_rd_data = '0; m_ts = '0;
         return;
      end
      m_ts = m_ts + 1'b1;
      case (m_state)
         0: if (arm) begin m_q.delete(); m_trig = 1'b0; m_state = 1; end
         1: begin
            if (sample_valid) begin
               m_q.push_back(e);
               if (!hit && m_q.size() > PRE_TRIG) void'(m_q.pop_front());
            end
            if (hit) begin
               m_trig = 1'b1;
               m_post = DEPTH - PRE_TRIG - 1;
               m_state = (m_post == 0 || stop) ? 3 : 2;
            end else if (stop) m_state = 3;
         end
         2: begin
            if (sample_valid) begin m_q.push_back(e); m_post--; end
            if (stop || (sample_valid && m_post == 0)) m_state = 3;
         end
         default: begin
            if (arm) begin m_q.delete(); m_trig = 1'b0; m_state = 1; end
            else if (rd_req && m_q.size() > 0) begin
               m_rd_data  = m_q.pop_front();
               m_rd_valid = 1'b1;
               m_rd_last  = (m_q.size() == 0);
            end
         end
      endcase
   endtask

   // Per-cycle comparison of all outputs against the model.
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("state", 64'(state), 64'(m_state));
         chk("count", 64'(count), 64'(m_q.size()));
         chk("triggered", 64'(triggered), 64'(m_trig));
         chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
         if (m_rd_valid) begin
            chk("rd_data", 64'(rd_data), 64'(m_rd_data));
            chk("rd_last", 64'(rd_last), 64'(m_rd_last));
         end
      end
   end

   // One clock cycle: drive at the falling edge, model steps at the rising edge.
   task automatic cyc(input bit sv, input logic [INSTR_W-1:0] ins, input bit ar,
                      input bit st, input bit rq, input bit rs);
      sample_valid = sv;
      instr        = ins;
      ALUResult    = ins[DATA_W-1:0];
      cpu_out      = DATA_W'($urandom);
      arm = ar; stop = st; rd_req = rq; reset = rs;
      @(posedge CLK);
      m_step();
      @(negedge CLK);
      #1;
   endtask

   function automatic logic [INSTR_W-1:0] rd_instr();
      return rd_data[2*DATA_W +: INSTR_W];
   endfunction

   initial begin
      sample_valid = 0; instr = '0; ALUResult = '0; cpu_out = '0;
      arm = 0; stop = 0; rd_req = 0; reset = 1;
      trig_value = '0; trig_mask = '0;
      @(negedge CLK);
      cyc(0, '0, 0, 0, 0, 1);
      cyc(0, '0, 0, 0, 0, 1);
      chk_en = 1'b1;

      // Reset values.
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_trig", 64'(triggered), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd_last", 64'(rd_last), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);

      // Idle: samples without arm are not captured, reads ignored.
      for (int i = 1; i <= 5; i++) cyc(1, INSTR_W'(i), 0, 0, 0, 0);
      cyc(0, '0, 0, 0, 1, 0);
      cyc(0, '0, 0, 0, 0, 0);
      chk("idle_state", 64'(state), 64'd0);
      chk("idle_count", 64'(count), 64'd0);

      // Basic capture.
      trig_mask = 24'hFFFFFF; trig_value = 24'h0000AA;
      cyc(0, '0, 1, 0, 0, 0);
      for (int i = 1; i <= 20; i++) cyc(1, INSTR_W'(i), 0, 0, 0, 0);
      cyc(1, 24'h0000AA, 0, 0, 0, 0);
      for (int i = 0; i < 11; i++) cyc(1, INSTR_W'(21 + i), 0, 0, 0, 0);
      chk("basic_state", 64'(state), 64'd3);
      chk("basic_count", 64'(count), 64'd16);
      chk("basic_model_count", 64'(m_q.size()), 64'd16);
      chk("basic_trig", 64'(triggered), 64'd1);
      for (int i = 0; i < 16; i++) begin
         logic [INSTR_W-1:0] exp_i;
         exp_i = (i < 4) ? INSTR_W'(32'h11 + i) : (i == 4) ? 24'h0000AA : INSTR_W'(32'h15 + i - 5);
         cyc(0, '0, 0, 0, 1, 0);
         chk("basic_rd_valid", 64'(rd_valid), 64'd1);
         chk("basic_rd_instr", 64'(rd_instr()), 64'(exp_i));
         chk("basic_rd_alu", 64'(rd_data[DATA_W +: DATA_W]), 64'(exp_i[7:0]));
         chk("basic_rd_last", 64'(rd_last), 64'(i == 15));
      end
      cyc(0, '0, 0, 0, 1, 0);
      chk("empty_rd_valid", 64'(rd_valid), 64'd0);

      // Early trigger: mask of zero hits on the first valid sample.
      trig_mask = '0;
      cyc(0, '0, 1, 0, 0, 0);
      cyc(1, 24'h123456, 0, 0, 0, 0);
      for (int i = 0; i < 11; i++) cyc(1, INSTR_W'($urandom), 0, 0, 0, 0);
      chk("early_count", 64'(count), 64'd12);
      chk("early_state", 64'(state), 64'd3);
      cyc(0, '0, 0, 0, 1, 0);
      chk("early_first", 64'(rd_instr()), 64'h123456);

      // Stop without trigger (arm also discards the unread remainder).
      trig_mask = 24'hFFFFFF; trig_value = 24'hFFFFFF;
      cyc(0, '0, 1, 0, 1, 0);
      chk("arm_beats_rd", 64'(rd_valid), 64'd0);
      for (int i = 1; i <= 7; i++) cyc(1, INSTR_W'(i), 0, 0, 0, 0);
      cyc(0, '0, 0, 1, 0, 0);
      chk("stop_state", 64'(state), 64'd3);
      chk("stop_count", 64'(count), 64'd4);
      chk("stop_trig", 64'(triggered), 64'd0);
      for (int i = 4; i <= 7; i++) begin
         cyc(0, '0, 0, 0, 1, 0);
         chk("stop_rd_instr", 64'(rd_instr()), 64'(i));
      end

      // Gap in sample_valid during POST leaves the post window intact.
      trig_value = 24'h0000AA;
      cyc(0, '0, 1, 0, 0, 0);
      cyc(1, 24'h0000AA, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, INSTR_W'(i), 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, INSTR_W'(i), 0, 0, 0, 0);
      chk("gap_count", 64'(count), 64'd4);
      chk("gap_state", 64'(state), 64'd2);
      for (int i = 0; i < 7; i++) cyc(1, INSTR_W'(i), 0, 0, 0, 0);
      chk("gap_still_post", 64'(state), 64'd2);
      cyc(1, 24'h0, 0, 0, 0, 0);
      chk("gap_done", 64'(state), 64'd3);
      chk("gap_final_count", 64'(count), 64'd12);

      // Reset during POST with five post samples left.
      cyc(0, '0, 1, 0, 0, 0);
      cyc(1, 24'h0000AA, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(1, INSTR_W'(i), 0, 0, 0, 0);
      chk("prerst_state", 64'(state), 64'd2);
      cyc(1, 24'h1, 0, 0, 0, 1);
      chk("midrst_state", 64'(state), 64'd0);
      chk("midrst_count", 64'(count), 64'd0);
      chk("midrst_trig", 64'(triggered), 64'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         if (n % 500 == 0) begin
            trig_mask  = ($urandom_range(0, 3) == 0) ? '0 : 24'h000007;
            trig_value = INSTR_W'($urandom);
         end
         cyc($urandom_range(0, 9) < 7, INSTR_W'($urandom),
             $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
